// File: rtl/axi_rd_arbiter_2x1.sv
// Two-master AXI read arbiter in front of the single-port SRAM bridge; one read in flight.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration, otherwise m0 has fixed priority.
module axi_rd_arbiter_2x1 #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input  logic              aclk,
   input  logic              areset,
   // master 0 (instruction fetch)
   input  logic [ADDR_W-1:0] m0_araddr,
   input  logic [ID_W-1:0]   m0_arid,
   input  logic [7:0]        m0_arlen,
   input  logic [2:0]        m0_arsize,
   input  logic [1:0]        m0_arburst,
   input  logic [2:0]        m0_arprot,
   input  logic [3:0]        m0_arcache,
   input  logic [1:0]        m0_arlock,
   input  logic              m0_arvalid,
   output logic              m0_arready,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [ID_W-1:0]   m0_rid,
   output logic [1:0]        m0_rresp,
   output logic              m0_rlast,
   output logic              m0_rvalid,
   input  logic              m0_rready,
   // master 1 (data)
   input  logic [ADDR_W-1:0] m1_araddr,
   input  logic [ID_W-1:0]   m1_arid,
   input  logic [7:0]        m1_arlen,
   input  logic [2:0]        m1_arsize,
   input  logic [1:0]        m1_arburst,
   input  logic [2:0]        m1_arprot,
   input  logic [3:0]        m1_arcache,
   input  logic [1:0]        m1_arlock,
   input  logic              m1_arvalid,
   output logic              m1_arready,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ID_W-1:0]   m1_rid,
   output logic [1:0]        m1_rresp,
   output logic              m1_rlast,
   output logic              m1_rvalid,
   input  logic              m1_rready,
   // bridge side
   output logic [ADDR_W-1:0] s_araddr,
   output logic [ID_W-1:0]   s_arid,
   output logic [7:0]        s_arlen,
   output logic [2:0]        s_arsize,
   output logic [1:0]        s_arburst,
   output logic [2:0]        s_arprot,
   output logic [3:0]        s_arcache,
   output logic [1:0]        s_arlock,
   output logic              s_arvalid,
   input  logic              s_arready,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic [ID_W-1:0]   s_rid,
   input  logic [1:0]        s_rresp,
   input  logic              s_rlast,
   input  logic              s_rvalid,
   output logic              s_rready
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   logic [1:0]      state_q;
   logic            grant_q;
   logic [ID_W-1:0] rid_q;
   logic            win;
   logic            in_addr;
   logic            in_data;
   logic            g_arvalid;
   logic [ID_W-1:0] g_arid;
   logic            retire;
   logic            unused_rid;

   // The bridge always answers with ID 0; the stored ARID replaces it.
   assign unused_rid = ^s_rid;

   assign in_addr   = (state_q == ST_ADDR);
   assign in_data   = (state_q == ST_DATA);
   assign g_arvalid = grant_q ? m1_arvalid : m0_arvalid;
   assign g_arid    = grant_q ? m1_arid    : m0_arid;
   assign retire    = in_data && s_rvalid && s_rready && s_rlast;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_grant_q;

   always_ff @(posedge aclk) begin
      if (areset) begin
         last_grant_q <= 1'b1;
      end else if (retire) begin
         last_grant_q <= grant_q;
      end
   end
`endif

   always_comb begin
      win = grant_q;
      if (m0_arvalid && m1_arvalid) begin
`ifdef ARB_ROUND_ROBIN_EN
         win = ~last_grant_q;
`else
         win = 1'b0;
`endif
      end else if (m0_arvalid) begin
         win = 1'b0;
      end else if (m1_arvalid) begin
         win = 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q <= ST_IDLE;
         grant_q <= 1'b0;
         rid_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (m0_arvalid || m1_arvalid) begin
                  grant_q <= win;
                  state_q <= ST_ADDR;
               end
            end
            ST_ADDR: begin
               if (g_arvalid && s_arready) begin
                  rid_q   <= g_arid;
                  state_q <= ST_DATA;
               end else if (!g_arvalid) begin
                  // requester withdrew before acceptance: abandon without forwarding
                  state_q <= ST_IDLE;
               end
            end
            ST_DATA: begin
               if (retire) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      s_araddr  = '0;
      s_arid    = '0;
      s_arlen   = '0;
      s_arsize  = '0;
      s_arburst = '0;
      s_arprot  = '0;
      s_arcache = '0;
      s_arlock  = '0;
      s_arvalid = 1'b0;
      if (in_addr) begin
         s_arvalid = g_arvalid;
         if (grant_q) begin
            s_araddr  = m1_araddr;
            s_arid    = m1_arid;
            s_arlen   = m1_arlen;
            s_arsize  = m1_arsize;
            s_arburst = m1_arburst;
            s_arprot  = m1_arprot;
            s_arcache = m1_arcache;
            s_arlock  = m1_arlock;
         end else begin
            s_araddr  = m0_araddr;
            s_arid    = m0_arid;
            s_arlen   = m0_arlen;
            s_arsize  = m0_arsize;
            s_arburst = m0_arburst;
            s_arprot  = m0_arprot;
            s_arcache = m0_arcache;
            s_arlock  = m0_arlock;
         end
      end
   end

   assign m0_arready = in_addr && !grant_q && s_arready;
   assign m1_arready = in_addr &&  grant_q && s_arready;
   assign s_rready   = in_data && (grant_q ? m1_rready : m0_rready);

   // Return path: only the granted master sees the beat, the other reads all zeros.
   always_comb begin
      m0_rdata  = '0;
      m0_rid    = '0;
      m0_rresp  = '0;
      m0_rlast  = 1'b0;
      m0_rvalid = 1'b0;
      m1_rdata  = '0;
      m1_rid    = '0;
      m1_rresp  = '0;
      m1_rlast  = 1'b0;
      m1_rvalid = 1'b0;
      if (in_data) begin
         if (grant_q) begin
            m1_rdata  = s_rdata;
            m1_rid    = rid_q;
            m1_rresp  = s_rresp;
            m1_rlast  = s_rlast;
            m1_rvalid = s_rvalid;
         end else begin
            m0_rdata  = s_rdata;
            m0_rid    = rid_q;
            m0_rresp  = s_rresp;
            m0_rlast  = s_rlast;
            m0_rvalid = s_rvalid;
         end
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter_2x1.sv
// Directed bench for axi_rd_arbiter_2x1: per-cycle vector table plus hand-written corner sequences.
module tb_axi_rd_arbiter_2x1;

   logic        aclk = 1'b0;
   logic        areset;
   logic [31:0] m0_araddr, m1_araddr, s_araddr;
   logic [3:0]  m0_arid, m1_arid, s_arid;
   logic [7:0]  m0_arlen, m1_arlen, s_arlen;
   logic [2:0]  m0_arsize, m1_arsize, s_arsize;
   logic [1:0]  m0_arburst, m1_arburst, s_arburst;
   logic [2:0]  m0_arprot, m1_arprot, s_arprot;
   logic [3:0]  m0_arcache, m1_arcache, s_arcache;
   logic [1:0]  m0_arlock, m1_arlock, s_arlock;
   logic        m0_arvalid, m1_arvalid, s_arvalid;
   logic        m0_arready, m1_arready, s_arready;
   logic [31:0] m0_rdata, m1_rdata, s_rdata;
   logic [3:0]  m0_rid, m1_rid, s_rid;
   logic [1:0]  m0_rresp, m1_rresp, s_rresp;
   logic        m0_rlast, m1_rlast, s_rlast;
   logic        m0_rvalid, m1_rvalid, s_rvalid;
   logic        m0_rready, m1_rready, s_rready;

   int checks = 0;
   int errors = 0;

   always #5 aclk = ~aclk;

   axi_rd_arbiter_2x1 #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) dut (
      .aclk(aclk), .areset(areset),
      .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
      .m0_arburst(m0_arburst), .m0_arprot(m0_arprot), .m0_arcache(m0_arcache), .m0_arlock(m0_arlock),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_rdata(m0_rdata), .m0_rid(m0_rid),
      .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
      .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
      .m1_arburst(m1_arburst), .m1_arprot(m1_arprot), .m1_arcache(m1_arcache), .m1_arlock(m1_arlock),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_rdata(m1_rdata), .m1_rid(m1_rid),
      .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
      .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arburst(s_arburst), .s_arprot(s_arprot), .s_arcache(s_arcache), .s_arlock(s_arlock),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata), .s_rid(s_rid),
      .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready)
   );

   typedef struct {
      logic        m0v;  logic [31:0] m0a;  logic [3:0] m0id;
      logic        m1v;  logic [31:0] m1a;  logic [3:0] m1id;
      logic        sardy; logic srv; logic [31:0] srd; logic srl; logic rrdy;
      logic        e_sarv; logic [31:0] e_sa; logic e_m0ar; logic e_m1ar; logic e_srr;
      logic        e_m0rv; logic e_m1rv; logic [31:0] e_m0rd; logic [31:0] e_m1rd;
      logic [3:0]  e_m0id; logic [3:0] e_m1id;
   } vec_t;

   localparam int NV = 12;
   vec_t tbl [NV];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_inputs;
      m0_arvalid = 1'b0; m0_araddr = '0; m0_arid = '0;
      m1_arvalid = 1'b0; m1_araddr = '0; m1_arid = '0;
      s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rlast = 1'b0; s_rresp = '0; s_rid = '0;
      m0_rready = 1'b0; m1_rready = 1'b0;
   endtask

   task automatic next_cycle;
      @(posedge aclk);
      #1;
   endtask

   task automatic do_reset;
      areset = 1'b1;
      clear_inputs();
      next_cycle();
      next_cycle();
      areset = 1'b0;
   endtask

   task automatic chk_all_quiet(input string tag);
      chk({tag, " s_arvalid"}, s_arvalid, 0);
      chk({tag, " s_rready"}, s_rready, 0);
      chk({tag, " m0_arready"}, m0_arready, 0);
      chk({tag, " m1_arready"}, m1_arready, 0);
      chk({tag, " m0_rvalid"}, m0_rvalid, 0);
      chk({tag, " m1_rvalid"}, m1_rvalid, 0);
      chk({tag, " m0_rdata"}, m0_rdata, 0);
      chk({tag, " m1_rdata"}, m1_rdata, 0);
      chk({tag, " m0_rid"}, m0_rid, 0);
      chk({tag, " s_araddr"}, s_araddr, 0);
   endtask

   initial begin
      logic exp_w;
      m0_arlen = 8'h03; m0_arsize = 3'd2; m0_arburst = 2'd1; m0_arprot = 3'd4; m0_arcache = 4'h2; m0_arlock = 2'd0;
      m1_arlen = 8'h0F; m1_arsize = 3'd1; m1_arburst = 2'd2; m1_arprot = 3'd1; m1_arcache = 4'h3; m1_arlock = 2'd1;

      //         m0v m0a    id m1v m1a    id ardy rv rdata         rl rr | sarv sa     m0ar m1ar srr m0rv m1rv m0rd          m1rd          m0id m1id
      tbl[0]  = '{1, 'h100, 3, 0, 0,     0, 1,   0, 0,            0, 1,  0,   0,     0,   0,   0,  0,   0,   0,            0,            0,   0};
      tbl[1]  = '{1, 'h100, 3, 0, 0,     0, 1,   0, 0,            0, 1,  1,   'h100, 1,   0,   0,  0,   0,   0,            0,            0,   0};
      tbl[2]  = '{0, 0,     0, 0, 0,     0, 1,   1, 'hDEADBEEF,   1, 1,  0,   0,     0,   0,   1,  1,   0,   'hDEADBEEF,   0,            3,   0};
      tbl[3]  = '{0, 0,     0, 0, 0,     0, 1,   1, 'hCAFE0000,   1, 1,  0,   0,     0,   0,   0,  0,   0,   0,            0,            0,   0};
      tbl[4]  = '{0, 0,     0, 1, 'h200, 5, 1,   0, 0,            0, 1,  0,   0,     0,   0,   0,  0,   0,   0,            0,            0,   0};
      tbl[5]  = '{0, 0,     0, 1, 'h200, 5, 1,   1, 'h55555555,   1, 1,  1,   'h200, 0,   1,   0,  0,   0,   0,            0,            0,   0};
      tbl[6]  = '{0, 0,     0, 0, 0,     0, 1,   1, 'h12345678,   1, 1,  0,   0,     0,   0,   1,  0,   1,   0,            'h12345678,   0,   5};
      tbl[7]  = '{1, 'h300, 7, 0, 0,     0, 1,   0, 0,            0, 1,  0,   0,     0,   0,   0,  0,   0,   0,            0,            0,   0};
      tbl[8]  = '{1, 'h300, 7, 0, 0,     0, 1,   0, 0,            0, 1,  1,   'h300, 1,   0,   0,  0,   0,   0,            0,            0,   0};
      tbl[9]  = '{0, 0,     0, 0, 0,     0, 1,   1, 'hA0A0A0A0,   0, 1,  0,   0,     0,   0,   1,  1,   0,   'hA0A0A0A0,   0,            7,   0};
      tbl[10] = '{0, 0,     0, 0, 0,     0, 1,   1, 'hB1B1B1B1,   1, 1,  0,   0,     0,   0,   1,  1,   0,   'hB1B1B1B1,   0,            7,   0};
      tbl[11] = '{0, 0,     0, 0, 0,     0, 0,   0, 0,            0, 0,  0,   0,     0,   0,   0,  0,   0,   0,            0,            0,   0};

      // reset state, with a stray bridge beat present
      do_reset();
      s_rvalid = 1'b1; s_rdata = 32'h0BADF00D; s_rlast = 1'b1;
      @(negedge aclk);
      chk_all_quiet("reset");
      next_cycle();
      clear_inputs();

      for (int i = 0; i < NV; i++) begin
         m0_arvalid = tbl[i].m0v; m0_araddr = tbl[i].m0a; m0_arid = tbl[i].m0id;
         m1_arvalid = tbl[i].m1v; m1_araddr = tbl[i].m1a; m1_arid = tbl[i].m1id;
         s_arready = tbl[i].sardy; s_rvalid = tbl[i].srv; s_rdata = tbl[i].srd; s_rlast = tbl[i].srl;
         m0_rready = tbl[i].rrdy; m1_rready = tbl[i].rrdy;
         @(negedge aclk);
         chk($sformatf("v%0d s_arvalid", i), s_arvalid, tbl[i].e_sarv);
         chk($sformatf("v%0d s_araddr", i), s_araddr, tbl[i].e_sa);
         chk($sformatf("v%0d m0_arready", i), m0_arready, tbl[i].e_m0ar);
         chk($sformatf("v%0d m1_arready", i), m1_arready, tbl[i].e_m1ar);
         chk($sformatf("v%0d s_rready", i), s_rready, tbl[i].e_srr);
         chk($sformatf("v%0d m0_rvalid", i), m0_rvalid, tbl[i].e_m0rv);
         chk($sformatf("v%0d m1_rvalid", i), m1_rvalid, tbl[i].e_m1rv);
         chk($sformatf("v%0d m0_rdata", i), m0_rdata, tbl[i].e_m0rd);
         chk($sformatf("v%0d m1_rdata", i), m1_rdata, tbl[i].e_m1rd);
         chk($sformatf("v%0d m0_rid", i), m0_rid, tbl[i].e_m0id);
         chk($sformatf("v%0d m1_rid", i), m1_rid, tbl[i].e_m1id);
         next_cycle();
      end

      // simultaneous requests held for four reads
      do_reset();
      m0_arvalid = 1'b1; m0_araddr = 32'h10; m0_arid = 4'd1;
      m1_arvalid = 1'b1; m1_araddr = 32'h20; m1_arid = 4'd2;
      s_arready = 1'b1; m0_rready = 1'b1; m1_rready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         s_rvalid = 1'b0; s_rlast = 1'b0;
         @(negedge aclk);
         chk($sformatf("sim%0d idle s_arvalid", k), s_arvalid, 0);
         next_cycle();
`ifdef ARB_ROUND_ROBIN_EN
         exp_w = (k % 2 == 1);
`else
         exp_w = 1'b0;
`endif
         @(negedge aclk);
         chk($sformatf("sim%0d m0_arready", k), m0_arready, !exp_w);
         chk($sformatf("sim%0d m1_arready", k), m1_arready, exp_w);
         chk($sformatf("sim%0d s_araddr", k), s_araddr, exp_w ? 32'h20 : 32'h10);
         next_cycle();
         s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 32'h1000 + k;
         @(negedge aclk);
         chk($sformatf("sim%0d m0_rvalid", k), m0_rvalid, !exp_w);
         chk($sformatf("sim%0d m1_rvalid", k), m1_rvalid, exp_w);
         chk($sformatf("sim%0d rid", k), exp_w ? m1_rid : m0_rid, exp_w ? 4'd2 : 4'd1);
         next_cycle();
      end
      clear_inputs();

      // m1 stalls its R channel for 5 cycles while m0 waits
      do_reset();
      m1_arvalid = 1'b1; m1_araddr = 32'h40; m1_arid = 4'd4; s_arready = 1'b1; m0_rready = 1'b1;
      next_cycle();
      m0_arvalid = 1'b1; m0_araddr = 32'h60; m0_arid = 4'd6;
      @(negedge aclk);
      chk("hold m1_arready", m1_arready, 1);
      next_cycle();
      m1_arvalid = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 32'h77;
      for (int j = 0; j < 5; j++) begin
         @(negedge aclk);
         chk($sformatf("hold%0d s_rready", j), s_rready, 0);
         chk($sformatf("hold%0d m1_rvalid", j), m1_rvalid, 1);
         chk($sformatf("hold%0d m0_arready", j), m0_arready, 0);
         chk($sformatf("hold%0d s_arvalid", j), s_arvalid, 0);
         next_cycle();
      end
      m1_rready = 1'b1;
      @(negedge aclk);
      chk("hold retire s_rready", s_rready, 1);
      chk("hold retire m1_rdata", m1_rdata, 32'h77);
      chk("hold retire m1_rid", m1_rid, 4'd4);
      next_cycle();
      s_rvalid = 1'b0;
      @(negedge aclk);
      chk("hold idle m0_arready", m0_arready, 0);
      next_cycle();
      @(negedge aclk);
      chk("hold m0 granted", m0_arready, 1);
      chk("hold m0 s_araddr", s_araddr, 32'h60);
      next_cycle();
      m0_arvalid = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h66;
      @(negedge aclk);
      chk("hold m0 rid", m0_rid, 4'd6);
      next_cycle();
      clear_inputs();

      // bridge holds off AR for 3 cycles
      do_reset();
      m0_arvalid = 1'b1; m0_araddr = 32'h50; m0_arid = 4'd2; m0_rready = 1'b1;
      next_cycle();
      for (int j = 0; j < 3; j++) begin
         @(negedge aclk);
         chk($sformatf("stall%0d s_arvalid", j), s_arvalid, 1);
         chk($sformatf("stall%0d s_araddr", j), s_araddr, 32'h50);
         chk($sformatf("stall%0d m0_arready", j), m0_arready, 0);
         next_cycle();
      end
      s_arready = 1'b1;
      @(negedge aclk);
      chk("stall go m0_arready", m0_arready, 1);
      chk("stall go s_arvalid", s_arvalid, 1);
      chk("stall go s_arlen", s_arlen, 8'h03);
      chk("stall go s_arcache", s_arcache, 4'h2);
      next_cycle();
      m0_arvalid = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1; s_rresp = 2'd2; s_rdata = 32'h5A5A;
      @(negedge aclk);
      chk("stall m0_rresp", m0_rresp, 2'd2);
      chk("stall m0_rlast", m0_rlast, 1);
      chk("stall m0_rid", m0_rid, 4'd2);
      next_cycle();
      clear_inputs();

      // granted master withdraws its request in ADDR
      do_reset();
      m0_arvalid = 1'b1; m0_araddr = 32'h80; m0_arid = 4'd1;
      m1_arvalid = 1'b1; m1_araddr = 32'h90; m1_arid = 4'hA; m1_rready = 1'b1;
      next_cycle();
      @(negedge aclk);
      chk("drop m0 s_araddr", s_araddr, 32'h80);
      next_cycle();
      m0_arvalid = 1'b0; s_arready = 1'b1;
      @(negedge aclk);
      chk("drop s_arvalid", s_arvalid, 0);
      next_cycle();
      @(negedge aclk);
      chk("drop idle s_arvalid", s_arvalid, 0);
      chk("drop idle m0_arready", m0_arready, 0);
      chk("drop idle m1_arready", m1_arready, 0);
      next_cycle();
      @(negedge aclk);
      chk("drop m1 arready", m1_arready, 1);
      chk("drop m1 s_arid", s_arid, 4'hA);
      chk("drop m1 s_araddr", s_araddr, 32'h90);
      chk("drop m1 s_arlen", s_arlen, 8'h0F);
      next_cycle();
      m1_arvalid = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 32'h9999;
      @(negedge aclk);
      chk("drop m1_rvalid", m1_rvalid, 1);
      chk("drop m1_rid", m1_rid, 4'hA);
      next_cycle();
      clear_inputs();

      // reset pulsed while a read is in DATA
      do_reset();
      m0_arvalid = 1'b1; m0_araddr = 32'hA0; m0_arid = 4'hC; s_arready = 1'b1; m0_rready = 1'b1;
      next_cycle();
      next_cycle();
      m0_arvalid = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b0; s_rdata = 32'hFEED;
      @(negedge aclk);
      chk("rst pre m0_rvalid", m0_rvalid, 1);
      areset = 1'b1;
      next_cycle();
      areset = 1'b0;
      @(negedge aclk);
      chk_all_quiet("rst post");
      next_cycle();
      s_rvalid = 1'b0; m1_arvalid = 1'b1; m1_araddr = 32'hB0; m1_arid = 4'd9; m1_rready = 1'b1;
      next_cycle();
      @(negedge aclk);
      chk("rst m1_arready", m1_arready, 1);
      next_cycle();
      m1_arvalid = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 32'hB0B0;
      @(negedge aclk);
      chk("rst m1_rvalid", m1_rvalid, 1);
      chk("rst m1_rid", m1_rid, 4'd9);
      chk("rst m1_rdata", m1_rdata, 32'hB0B0);
      next_cycle();
      clear_inputs();
      next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_rd_arbiter_2x1.md
# axi_rd_arbiter_2x1

Two-master AXI read arbiter that shares the single-port SRAM read path between an instruction-fetch master (m0) and a data master (m1). It sits directly in front of the AXI-to-SRAM bridge and drives that bridge's AR/R channels. It grants one master at a time and holds the grant until that master's single-beat read retires. It restores each master's ARID on the returned R beat, because the bridge always returns ID 0.

## Interface
Parameters:
- ADDR_W, 32, address width of m0/m1/s AR channels
- DATA_W, 32, read data width
- ID_W, 4, ARID/RID width

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  reset; synchronous, active-high
- mX_araddr  in  ADDR_W  master X read address (X = 0, 1)
- mX_arid  in  ID_W  master X transaction ID
- mX_arlen/arsize/arburst/arprot/arcache/arlock  in  8/3/2/3/4/2  master X AR attributes; passed through
- mX_arvalid  in  1  master X request
- mX_arready  out  1  master X request accepted
- mX_rdata  out  DATA_W  read data to master X
- mX_rid  out  ID_W  stored ARID of the granted master X
- mX_rresp  out  2  response, from slave
- mX_rlast  out  1  from slave
- mX_rvalid  out  1  read beat valid to master X
- mX_rready  in  1  master X accepts beat
- s_araddr, s_arid, s_ar* attributes  out  as above  AR channel to bridge, muxed from the granted master
- s_arvalid  out  1;  s_arready  in  1
- s_rdata  in  DATA_W;  s_rid  in  ID_W (ignored);  s_rresp  in  2;  s_rlast  in  1;  s_rvalid  in  1;  s_rready  out  1

## Operation
- State machine: IDLE, ADDR, DATA. One outstanding transaction in total.
- IDLE:
  - If any mX_arvalid is high, pick a winner per Configuration, register grant, and go to ADDR.
  - All arready, rvalid, s_arvalid and s_rready are 0.
- ADDR:
  - s_ar* = granted master's AR fields; s_arvalid = granted mX_arvalid; granted mX_arready = s_arready; the other master's arready = 0.
  - On s_arvalid & s_arready: capture the granted master's arid into rid_q and go to DATA.
  - If the granted mX_arvalid drops before acceptance (protocol violation), return to IDLE with no forward.
- DATA:
  - Granted mX_rvalid = s_rvalid; s_rready = granted mX_rready; mX_rdata/rresp/rlast come from the slave; mX_rid = rid_q.
  - The other master's rvalid = 0.
  - On s_rvalid & s_rready & s_rlast: update last_grant, go to IDLE.
- Beats without rlast stay in DATA, so multi-beat bursts pass through correctly.
- s_rvalid arriving in IDLE or ADDR is not accepted (s_rready = 0).
- Non-granted mX_r* data outputs are driven to 0.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1 (m0 wins the first contest), rid_q = 0.
  - All valid/ready outputs = 0; all data outputs = 0.
- Arbitration latency:
  - arvalid seen in IDLE at cycle N → s_arvalid high at N+1.
  - With the bridge's s_arready = 1, mX_arready pulses at N+1.
- Bridge read data is valid one cycle after AR acceptance. With rready held high, the beat retires at N+2 and state is IDLE at N+3.
- Back-to-back minimum period: 3 cycles per read. New arbitration starts in the IDLE cycle following retirement.
- Simultaneous requests from m0 and m1 in IDLE are resolved by the policy in Configuration. The loser's arvalid stays pending with arready = 0.
- Reset asserted mid-transaction: the next cycle is IDLE with outputs at reset values; the outstanding read is dropped. The bridge shares the reset domain.
- Grant register, state and rid_q are flops. The AR/R muxes are combinational from state and grant; there is no data pipelining.

## Configuration
- Macro ARB_ROUND_ROBIN_EN:
  - Defined: round-robin. On a simultaneous request the master not in last_grant wins, and last_grant updates at each retirement.
  - Undefined: fixed priority, m0 always wins a simultaneous request. last_grant is not implemented.
- Single-master behaviour is identical in both builds.

## Test plan
- Single m0 read: araddr=0x100, arid=3; bridge returns 0xDEADBEEF → m0_rvalid at cycle 2, m0_rdata=0xDEADBEEF, m0_rid=3, m1_rvalid stays 0.
- Simultaneous m0 (arid=1) and m1 (arid=2) held for 4 reads:
  - With ARB_ROUND_ROBIN_EN: grant order m0, m1, m0, m1.
  - Without it: m0 four times while m1_arready stays 0.
- m1 holds rready=0 for 5 cycles in DATA → s_rready=0, state stays DATA, m0 request not granted until the m1 beat retires.
- Bridge s_arready=0 for 3 cycles in ADDR → s_arvalid and s_araddr held stable, granted arready=0, then both pulse together on cycle 4.
- Granted master drops arvalid in ADDR → return to IDLE, no s_arvalid & s_arready handshake occurs, and the other pending master is granted next.
- areset pulsed in DATA → next cycle all valid/ready outputs 0 and state IDLE; a subsequent m1 read completes normally with m1_rid equal to its own arid.
